// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, parity modes and width limits for the UART receive path
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD = 1;
  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;
endpackage

// File: rtl/uart_rx_deserializer_shift.sv
// rx_shift_core: serial-to-parallel shift register filling from the end selected by MSB_FIRST
module rx_shift_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] word
);
  logic [DATA_WIDTH-1:0] r_word = '0;
  always_ff @(posedge clk)
    if (!reset || clear) r_word <= '0;
    else if (shift_en) r_word <= (MSB_FIRST != 0) ? {r_word[DATA_WIDTH-2:0], bit_in} : {bit_in, r_word[DATA_WIDTH-1:1]};
  assign word = r_word;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: assembles strobed serial bits into words behind a valid/ready handshake
// Optional parity stage is enabled by defining RX_PARITY_EN.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  sampling_strobe,
  input  logic                  serial_in_synced,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun_error,
  output logic                  busy
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX || PARITY_ODD < PAR_EVEN || PARITY_ODD > PAR_ODD || MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_cfg
    $error("uart_rx_deserializer: illegal parameter value");
  end
  rx_state_t r_state = IDLE;
  rx_state_t w_next;
  logic [CNT_W-1:0] r_bit_cnt = '0;
  logic [DATA_WIDTH-1:0] r_data = '0;
  logic [DATA_WIDTH-1:0] w_word;
  logic r_valid = 1'b0;
  logic r_perr = 1'b0;
  logic r_ferr = 1'b0;
  logic r_ovr = 1'b0;
  logic w_clear, w_shift, w_done, w_load, w_perr;
  rx_shift_core #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
    .clk(clk),
    .reset(reset),
    .clear(w_clear),
    .shift_en(w_shift),
    .bit_in(serial_in_synced),
    .word(w_word)
  );
  always_comb begin
    w_next = r_state;
    w_clear = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = frame_start;
        w_next = frame_start ? DATA : IDLE;
      end
      DATA: begin
        w_shift = sampling_strobe;
        if (sampling_strobe && r_bit_cnt == CNT_W'(DATA_WIDTH - 1))
`ifdef RX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
      end
      PARITY: w_next = sampling_strobe ? STOP : PARITY;
      STOP: w_next = sampling_strobe ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  assign w_done = (r_state == STOP) && sampling_strobe;
  // A completing frame is accepted when the holding register is empty or being drained this cycle.
  assign w_load = w_done && (!r_valid || data_ready);
`ifdef RX_PARITY_EN
  logic r_par_bit = 1'b0;
  always_ff @(posedge clk)
    r_par_bit <= !reset ? 1'b0 : (r_state == PARITY && sampling_strobe) ? serial_in_synced : r_par_bit;
  assign w_perr = (^w_word ^ r_par_bit) != (PARITY_ODD == PAR_ODD);
`else
  assign w_perr = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      r_state <= IDLE;
      r_bit_cnt <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_bit_cnt <= w_clear ? '0 : w_shift ? r_bit_cnt + CNT_W'(1) : r_bit_cnt;
      if (w_load) begin
        r_data <= w_word;
        r_perr <= w_perr;
        r_ferr <= ~serial_in_synced;
      end
      r_valid <= w_load | (r_valid & ~data_ready);
      r_ovr <= w_done & r_valid & ~data_ready;
    end
  assign received_data = r_data;
  assign data_valid = r_valid;
  assign parity_error = r_perr;
  assign framing_error = r_ferr;
  assign overrun_error = r_ovr;
  assign busy = r_state != IDLE;
`ifdef FORMAL
  a_cnt_range: assert property (@(posedge clk) r_bit_cnt <= CNT_W'(DATA_WIDTH));
  a_latency: assert property (@(posedge clk) disable iff (!reset) w_done |=> data_valid);
  a_hold: assert property (@(posedge clk) disable iff (!reset)
    data_valid && !data_ready && !w_done |=> data_valid && $stable(received_data) && $stable(parity_error) && $stable(framing_error));
  a_overrun: assert property (@(posedge clk) disable iff (!reset)
    w_done && data_valid && !data_ready |=> data_valid && overrun_error && $stable(received_data));
  a_swap: assert property (@(posedge clk) disable iff (!reset) w_done && data_valid && data_ready |=> data_valid && !overrun_error);
  a_drain: assert property (@(posedge clk) disable iff (!reset) data_valid && data_ready && !w_done |=> !data_valid);
  a_ovr_cause: assert property (@(posedge clk) disable iff (!reset) !(w_done && data_valid && !data_ready) |=> !overrun_error);
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: scoreboard bench driving LSB-first and MSB-first receivers from one stream
module tb_uart_rx_deserializer;
  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_start = 1'b0;
  logic sampling_strobe = 1'b0;
  logic serial_in_synced = 1'b1;
  logic data_ready = 1'b0;
  logic [7:0] l_data, m_data;
  logic l_valid, l_perr, l_ferr, l_ovr, l_busy;
  logic m_valid, m_perr, m_ferr, m_ovr, m_busy;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q_l[$];
  exp_t q_m[$];
  exp_t e_l, e_m;
  always #5 clk = ~clk;
  uart_rx_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .PARITY_ODD(0)) u_lsb (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sampling_strobe(sampling_strobe),
    .serial_in_synced(serial_in_synced), .data_ready(data_ready), .received_data(l_data),
    .data_valid(l_valid), .parity_error(l_perr), .framing_error(l_ferr),
    .overrun_error(l_ovr), .busy(l_busy)
  );
  uart_rx_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1), .PARITY_ODD(0)) u_msb (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sampling_strobe(sampling_strobe),
    .serial_in_synced(serial_in_synced), .data_ready(data_ready), .received_data(m_data),
    .data_valid(m_valid), .parity_error(m_perr), .framing_error(m_ferr),
    .overrun_error(m_ovr), .busy(m_busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (reset) begin
      if (l_valid && data_ready) begin
        if (q_l.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL lsb_unexpected_word: got %0h, expected no word", l_data);
        end else begin
          e_l = q_l.pop_front();
          check("lsb_data", l_data, e_l.d);
          check("lsb_parity_error", l_perr, e_l.pe);
          check("lsb_framing_error", l_ferr, e_l.fe);
        end
      end
      if (m_valid && data_ready) begin
        if (q_m.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL msb_unexpected_word: got %0h, expected no word", m_data);
        end else begin
          e_m = q_m.pop_front();
          check("msb_data", m_data, e_m.d);
          check("msb_parity_error", m_perr, e_m.pe);
          check("msb_framing_error", m_ferr, e_m.fe);
        end
      end
    end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic b);
    serial_in_synced = b;
    sampling_strobe = 1'b1;
    tick();
    sampling_strobe = 1'b0;
  endtask
  task automatic drain();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    tick();
  endtask
  task automatic start_and_bits(input logic [7:0] seq, input int nbits);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("busy_in_frame", {l_busy, m_busy}, 2'b11);
    for (int i = 7; i > 7 - nbits; i--) begin
      pulse(seq[i]);
      if (i == 4) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask
  // seq[7] is the first bit on the line; exp_l/exp_m are the hand-derived words for each bit order.
  task automatic send_frame(input logic [7:0] seq, input logic par, input logic stop,
                            input logic [7:0] exp_l, input logic [7:0] exp_m, input logic pe,
                            input logic deliver, input logic stop_rdy, input logic pre_v, input logic exp_ovr);
    logic pe_e;
`ifdef RX_PARITY_EN
    pe_e = pe;
`else
    pe_e = 1'b0;
`endif
    start_and_bits(seq, 8);
`ifdef RX_PARITY_EN
    pulse(par);
    tick();
`endif
    check("valid_before_stop", {l_valid, m_valid}, {pre_v, pre_v});
    if (deliver) begin
      q_l.push_back('{d: exp_l, pe: pe_e, fe: ~stop});
      q_m.push_back('{d: exp_m, pe: pe_e, fe: ~stop});
    end
    data_ready = stop_rdy;
    pulse(stop);
    data_ready = 1'b0;
    check("valid_after_stop", {l_valid, m_valid}, 2'b11);
    check("busy_after_stop", {l_busy, m_busy}, 2'b00);
    check("overrun_pulse", {l_ovr, m_ovr}, {exp_ovr, exp_ovr});
    tick();
    check("overrun_one_cycle", {l_ovr, m_ovr}, 2'b00);
  endtask
  initial begin
    tick(3);
    check("reset_outputs", {l_data, l_valid, l_perr, l_ferr, l_ovr, l_busy, m_data, m_valid, m_perr, m_ferr, m_ovr, m_busy}, 0);
    reset = 1'b1;
    tick();
    pulse(1'b0);
    tick();
    check("strobe_ignored_in_idle", {l_busy, m_busy}, 2'b00);
    send_frame(8'b1010_0101, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    send_frame(8'b0011_1100, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    send_frame(8'b1101_0000, 1'b1, 1'b1, 8'h0B, 8'hD0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    send_frame(8'b1110_0000, 1'b0, 1'b1, 8'h07, 8'hE0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    send_frame(8'b1110_0000, 1'b1, 1'b1, 8'h07, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    send_frame(8'b1101_0000, 1'b1, 1'b0, 8'h0B, 8'hD0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {l_valid, m_valid}, 2'b11);
      check("hold_data", {l_data, m_data}, 16'h0BD0);
      check("hold_framing", {l_ferr, m_ferr}, 2'b11);
      tick();
    end
    drain();
    check("valid_cleared_after_ready", {l_valid, m_valid}, 2'b00);
    send_frame(8'b1010_0101, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'b0011_1100, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("overrun_retains_old", {l_data, m_data}, 16'hA5A5);
    drain();
    send_frame(8'b0011_1100, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'b1101_0000, 1'b0, 1'b1, 8'h0B, 8'hD0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("swap_loads_new", {l_data, m_data}, 16'h0BD0);
    drain();
    send_frame(8'b1010_0101, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    start_and_bits(8'b1111_0000, 4);
    reset = 1'b0;
    tick();
    check("midframe_reset_outputs", {l_data, l_valid, l_perr, l_ferr, l_ovr, l_busy, m_data, m_valid, m_perr, m_ferr, m_ovr, m_busy}, 0);
    q_l.delete();
    q_m.delete();
    reset = 1'b1;
    tick();
    send_frame(8'b0101_1010, 1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    check("lsb_queue_empty", q_l.size(), 0);
    check("msb_queue_empty", q_m.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
